// File: rtl/array_drain_pkg.sv
// Shared types and sizes for the MAC array and its result-readout sequencer.
package array_pkg;

    localparam int unsigned ARRAY_SIZE = 4;
    localparam int unsigned ACC_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LAST  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/array_drain_if.sv
// Control, array-select and result-stream signals between array_drain and its neighbours.
interface array_drain_if #(
    parameter int unsigned SIZE   = array_pkg::ARRAY_SIZE,
    parameter int unsigned DATA_W = array_pkg::ACC_W
);
    localparam int unsigned N     = SIZE * SIZE;
    localparam int unsigned IDX_W = $clog2(N);

    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [N-1:0]      select;
    logic [DATA_W-1:0] d_in;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [IDX_W-1:0]  res_idx;
    logic              res_last;

    // Controller, array and write-back side.
    modport master (
        output start, abort, d_in, res_ready,
        input  busy, done, select, res_valid, res_data, res_idx, res_last
    );

    // Drain sequencer side.
    modport slave (
        input  start, abort, d_in, res_ready,
        output busy, done, select, res_valid, res_data, res_idx, res_last
    );

endinterface

// File: rtl/array_drain_res_out_reg.sv
// Valid/ready output register for one result beat; loads only when empty or being consumed.
module res_out_reg
    import array_pkg::*;
#(
    parameter int unsigned DATA_W = ACC_W,
    parameter int unsigned IDX_W  = $clog2(ARRAY_SIZE * ARRAY_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              last_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              last_o,
    output logic              free_c
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  idx_q;
    logic              last_q;

    assign free_c = !valid_q || ready_i;

    // Clear wins over load so an abort or final handshake always empties the register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i && free_c) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            idx_q   <= idx_i;
            last_q  <= last_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;
    assign last_o  = last_q;

endmodule

// File: rtl/array_drain.sv
// Steps the MAC array select through every accumulator and streams each result with its index.
module array_drain
    import array_pkg::*;
#(
    parameter int unsigned SIZE   = ARRAY_SIZE,
    parameter int unsigned DATA_W = ACC_W
) (
    input  logic         clk,
    input  logic         reset,
    array_drain_if.slave bus
);

    localparam int unsigned      N        = SIZE * SIZE;
    localparam int unsigned      IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    drain_state_t     state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             busy_q;
    logic             done_q, done_d;
    logic             load_c;
    logic             clear_c;
    logic             free_c;
    logic             hs_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    assign hs_c = bus.res_valid && bus.res_ready;

    // Abort takes priority over both start and the final handshake.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        load_c  = 1'b0;
        clear_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = DRAIN;
                    sel_d   = '0;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    clear_c = 1'b1;
                end else if (free_c) begin
                    load_c = 1'b1;
                    if (sel_q == LAST_IDX) begin
                        state_d = LAST;
                    end else begin
                        sel_d = sel_q + IDX_W'(1);
                    end
                end
            end
            LAST: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    clear_c = 1'b1;
                end else if (hs_c) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    clear_c = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                clear_c = 1'b1;
            end
        endcase
    end

    // d_in is a same-cycle function of select, so the beat captured is the one for sel_q.
    res_out_reg #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_res_out (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load_c),
        .clear_i (clear_c),
        .ready_i (bus.res_ready),
        .data_i  (bus.d_in),
        .idx_i   (sel_q),
        .last_i  (sel_q == LAST_IDX),
        .valid_o (bus.res_valid),
        .data_o  (bus.res_data),
        .idx_o   (bus.res_idx),
        .last_o  (bus.res_last),
        .free_c  (free_c)
    );

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.select = N'(sel_q);

endmodule

// File: tb/tb_array_drain.sv
// Randomized and directed checks of array_drain against an index-queue reference model.
module tb_array_drain;

    localparam int N     = 16;
    localparam int IDX_W = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    array_drain_if bus ();

    array_drain dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [N];

    // Behavioural stand-in for the array output mux.
    always_comb bus.d_in = mem[bus.select[IDX_W-1:0]];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: expected next index, beat/done counts and busy flag.
    bit m_busy;
    int exp_idx;
    int beats;
    int dones;
    int cyc;
    int start_cyc;
    int done_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input int idx);
        return (idx >= 0 && idx < N) ? mem[idx] : 32'hDEAD_BEEF;
    endfunction

    // One clock: evaluate the pending edge from the current inputs, then compare after it.
    task automatic tick();
        bit          hs;
        bit          start_ok;
        bit          stalled;
        bit          ab;
        bit          want_done;
        logic [31:0] s_data;
        logic [3:0]  s_idx;
        logic        s_last;
        ab        = bus.abort;
        hs        = bus.res_valid && bus.res_ready && !ab;
        start_ok  = bus.start && !m_busy && !ab;
        stalled   = bus.res_valid && !bus.res_ready && !ab;
        s_data    = bus.res_data;
        s_idx     = bus.res_idx;
        s_last    = bus.res_last;
        want_done = 1'b0;
        chk("select_hi", 64'(bus.select >> IDX_W), 64'd0);
        if (hs) begin
            chk("beat_idx", 64'(bus.res_idx), 64'(exp_idx));
            chk("beat_data", 64'(bus.res_data), 64'(exp_data(exp_idx)));
            chk("beat_last", 64'(bus.res_last), 64'(exp_idx == N - 1));
            if (exp_idx == N - 1) want_done = 1'b1;
            exp_idx++;
            beats++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (start_ok) begin
            m_busy    = 1'b1;
            exp_idx   = 0;
            beats     = 0;
            start_cyc = cyc;
        end
        if (ab) m_busy = 1'b0;
        if (want_done) begin
            m_busy   = 1'b0;
            dones++;
            done_cyc = cyc;
        end
        chk("done", 64'(bus.done), 64'(want_done));
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("valid", 64'(bus.res_valid), 64'(m_busy && !start_ok));
        if (stalled) begin
            chk("stall_data", 64'(bus.res_data), 64'(s_data));
            chk("stall_idx", 64'(bus.res_idx), 64'(s_idx));
            chk("stall_last", 64'(bus.res_last), 64'(s_last));
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // mode 0: ready held, 1: ready toggles, 2: random ready plus stray start pulses.
    task automatic run_until_idle(input int bound, input int mode);
        int n;
        n = 0;
        while (m_busy && n < bound) begin
            if (mode == 1) bus.res_ready = !bus.res_ready;
            if (mode == 2) begin
                bus.res_ready = ($urandom_range(0, 9) < 6);
                bus.start     = ($urandom_range(0, 15) == 0);
            end
            tick();
            bus.start = 1'b0;
            n++;
        end
        if (m_busy) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_idx(input int target, input int bound);
        int n;
        n = 0;
        while (!(bus.res_valid && 32'(bus.res_idx) == target) && n < bound) begin
            tick();
            n++;
        end
        if (!(bus.res_valid && 32'(bus.res_idx) == target)) chk("wait_idx_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},  64'(bus.res_valid), 64'd0);
        chk({tag, "_busy"},   64'(bus.busy),      64'd0);
        chk({tag, "_done"},   64'(bus.done),      64'd0);
        chk({tag, "_select"}, 64'(bus.select),    64'd0);
        chk({tag, "_data"},   64'(bus.res_data),  64'd0);
        chk({tag, "_idx"},    64'(bus.res_idx),   64'd0);
        chk({tag, "_last"},   64'(bus.res_last),  64'd0);
    endtask

    initial begin
        int d0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 32'(i * 16 + 3);
        m_busy = 1'b0; exp_idx = 0; beats = 0; dones = 0; cyc = 0;
        start_cyc = 0; done_cyc = 0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;
        tick();
        tick();

        // Full-rate drain: latency and throughput.
        bus.res_ready = 1'b1;
        do_start();
        run_until_idle(40, 0);
        chk("t1_beats", 64'(beats), 64'(N));
        chk("t1_dones", 64'(dones), 64'd1);
        chk("t1_done_latency", 64'(done_cyc - start_cyc), 64'(N + 1));

        // Start in the cycle done is high.
        do_start();
        run_until_idle(40, 0);
        chk("t1b_beats", 64'(beats), 64'(N));
        chk("t1b_dones", 64'(dones), 64'd2);

        // Alternating ready.
        bus.res_ready = 1'b1;
        do_start();
        run_until_idle(80, 1);
        chk("t2_beats", 64'(beats), 64'(N));
        chk("t2_dones", 64'(dones), 64'd3);

        // Long stall on the first beat.
        bus.res_ready = 1'b0;
        do_start();
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_select", 64'(bus.select), 64'd1);
            chk("t3_idx", 64'(bus.res_idx), 64'd0);
            chk("t3_data", 64'(bus.res_data), 64'd3);
            chk("t3_busy", 64'(bus.busy), 64'd1);
        end
        bus.res_ready = 1'b1;
        run_until_idle(40, 0);
        chk("t3_beats", 64'(beats), 64'(N));

        // Abort at index 7, then a clean restart.
        d0 = dones;
        do_start();
        wait_idx(7, 40);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t4_valid", 64'(bus.res_valid), 64'd0);
        chk("t4_busy", 64'(bus.busy), 64'd0);
        tick();
        tick();
        chk("t4_no_done", 64'(dones), 64'(d0));
        do_start();
        run_until_idle(40, 0);
        chk("t4_restart_beats", 64'(beats), 64'(N));

        // Asynchronous reset between edges at index 5.
        do_start();
        wait_idx(5, 40);
        #2 reset = 1'b1;
        #1 check_all_zero("t5_async");
        @(negedge clk);
        reset   = 1'b0;
        m_busy  = 1'b0;
        exp_idx = 0;
        do_start();
        run_until_idle(40, 0);
        chk("t5_beats", 64'(beats), 64'(N));

        // Start while busy is ignored.
        do_start();
        wait_idx(4, 40);
        d0 = dones;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        run_until_idle(40, 0);
        chk("t6_beats", 64'(beats), 64'(N));
        chk("t6_one_done", 64'(dones), 64'(d0 + 1));

        // Random array contents and random back-pressure.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) mem[i] = $urandom;
            bus.res_ready = 1'b1;
            do_start();
            run_until_idle(300, 2);
            chk("rnd_beats", 64'(beats), 64'(N));
            bus.res_ready = 1'b1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/array_drain.md
Name: array_drain

Overview:
- Result-readout sequencer directly downstream of the SIZE x SIZE MAC array.
- After a compute pass, it steps the array's `select` index through all SIZE*SIZE accumulators and samples the 32-bit `d_out` for each one.
- Each result is presented as an indexed stream on a valid/ready interface to the write-back stage.
- `busy` tells the controller to hold `acc_en`/`load_en` low so accumulators stay stable during drain.

Parameters:
- SIZE, 4, array dimension; element count N = SIZE*SIZE.
- DATA_W, 32, width of accumulator result (matches array `d_out`).
- IDX_W, $clog2(SIZE*SIZE) (localparam), width of element index.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to drain array; honoured only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE, no done pulse.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after last element handshakes.
- select  output  SIZE*SIZE  binary element index, zero-extended, to array `select`.
- d_in  input  DATA_W  array `d_out`; combinational function of `select`.
- res_valid  output  1  result beat valid.
- res_ready  input  1  sink accepts beat.
- res_data  output  DATA_W  captured accumulator value.
- res_idx  output  IDX_W  element index of res_data (row*SIZE+col).
- res_last  output  1  high with the beat for index N-1.

Behaviour:
- Reset (async, any state, including mid-drain): state IDLE; sel counter 0; busy 0, done 0, res_valid 0, res_data 0, res_idx 0, res_last 0, select 0.
- States: IDLE, DRAIN, LAST.
- IDLE:
  - `start`=1 at edge k -> DRAIN, sel=0.
  - `start` in any other state is ignored.
- Output register "free" = !res_valid || res_ready. A beat handshakes on any edge where res_valid && res_ready.
- DRAIN, each edge with register free:
  - Capture res_data<=d_in, res_idx<=sel, res_valid<=1, res_last<=(sel==N-1).
  - If sel==N-1 -> LAST; else sel<=sel+1.
- DRAIN, register not free: hold everything (sel, select and output register stable).
- LAST: on handshake -> res_valid<=0, res_last<=0, done<=1 for one cycle, state IDLE, sel<=0.
- select mirrors sel combinationally. The d_in path is combinational through the array mux, so capture is same-cycle; no pipeline bubble.
- Timing with res_ready held 1:
  - first res_valid after edge k+1;
  - one beat per cycle, index 0..N-1 in order;
  - last beat after edge k+N;
  - done high after edge k+N+1.
- Zero-bubble rule: handshake and new capture on the same edge is mandatory. res_valid stays 1 across consecutive beats.
- Stall rule: while res_valid && !res_ready, res_data, res_idx and res_last stay constant.
- abort=1 (priority over start and handshake):
  - next edge: IDLE, res_valid 0, res_last 0, sel 0;
  - done not asserted; any partial beat is dropped.
- Widths: sel counts 0..N-1 with no wrap. select upper bits above IDX_W are always 0.
- done and start on the same cycle: done occurs only in LAST, so no conflict. A start in the cycle after done is honoured.

Decomposition:
- Package `array_pkg`:
  - drain_state_t enum {IDLE, DRAIN, LAST};
  - localparams ARRAY_SIZE=4 and ACC_W=32, shared with the array.
- One sub-module, `res_out_reg`: the valid/ready output register holding res_data/res_idx/res_last, with inputs load, clear, ready.
- Sequencing FSM and counter stay in the top.

Test Plan:
- Array preloaded so d_out[i]=i*16+3. Pulse start, res_ready=1 -> 16 beats on consecutive cycles, res_idx 0..15, res_data 3,19,...,243, res_last only on idx 15, done one cycle after.
- Same preload, res_ready toggling 1,0,1,0 -> every idx 0..15 delivered exactly once, in order. Outputs stable during each stall. done follows idx 15 handshake.
- Hold res_ready=0 for 10 cycles after first valid -> res_idx=0, res_data=3 held, select stays 1, busy=1 throughout.
- Abort asserted at beat idx 7 -> next cycle res_valid=0, busy=0, no done. A new start then restarts at idx 0.
- Async reset asserted mid-drain at idx 5, between clock edges -> outputs 0 immediately. After release, start yields a full 0..15 sequence.
- start pulsed again while busy (idx 4) -> ignored: sequence continues 5..15 and only one done is produced.
